// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types and layout helpers for the BE MMU command arbiter.
// Command = {mem_op, vaddr}; response = {exception_v, cache_miss_v, data}.
package bp_be_pkg;

   localparam int dword_width_gp   = 64;
   localparam int mem_op_width_gp  = 4;
   localparam int arb_id_width_gp  = 4;

   typedef enum logic [mem_op_width_gp-1:0] {
      e_lb  = 4'h0,
      e_lh  = 4'h1,
      e_lw  = 4'h2,
      e_ld  = 4'h3,
      e_sb  = 4'h8,
      e_sh  = 4'h9,
      e_sw  = 4'ha,
      e_sd  = 4'hb
   } bp_be_mmu_op_e;

   typedef struct packed {
      logic [arb_id_width_gp-1:0] id;
      logic                       poison;
   } bp_be_mmu_arb_entry_s;

   function automatic int mmu_cmd_width(input int vaddr_width);
      return mem_op_width_gp + vaddr_width;
   endfunction

   function automatic int mmu_resp_width();
      return dword_width_gp + 2;
   endfunction

   // Last-grant pointer starts at the highest index so requester 0 wins first.
   function automatic int rr_reset_ptr(input int els);
      return els - 1;
   endfunction

endpackage

// File: rtl/bp_be_mmu_id_tracker.sv
// bp_be_mmu_id_tracker: in-order FIFO of issued requester IDs.
// poison_all marks every resident entry; a same-cycle push keeps its own poison bit.
module bp_be_mmu_id_tracker
   import bp_be_pkg::*;
 #(parameter  int depth_p = 4,
   localparam int aw      = $clog2(depth_p))
  (input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 push_i,
   input  bp_be_mmu_arb_entry_s data_i,
   input  logic                 pop_i,
   input  logic                 poison_all_i,
   output bp_be_mmu_arb_entry_s head_o,
   output logic [aw:0]          count_o,
   output logic                 empty_o);

   bp_be_mmu_arb_entry_s mem [depth_p];
   logic [aw-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_o <= '0;
         for (int i = 0; i < depth_p; i++)
            mem[i] <= '0;
      end else begin
         if (poison_all_i)
            for (int i = 0; i < depth_p; i++)
               mem[i].poison <= 1'b1;
         if (push_i) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_i)
            rd_ptr <= rd_ptr + 1'b1;
         count_o <= count_o + (aw+1)'(push_i) - (aw+1)'(pop_i);
      end

   assign head_o  = mem[rd_ptr];
   assign empty_o = count_o == '0;

endmodule

// File: rtl/bp_be_mmu_cmd_arbiter.sv
// bp_be_mmu_cmd_arbiter: round-robin share of the BE MMU port among els_p requesters,
// with a one-entry holding register, credit limit and in-order response routing.
module bp_be_mmu_cmd_arbiter
   import bp_be_pkg::*;
 #(parameter  int vaddr_width_p             = 39,
   parameter  int lce_sets_p                = 64,
   parameter  int cce_block_size_in_bytes_p = 64,
   parameter  int els_p                     = 2,
   parameter  int outstanding_p             = 4,
   localparam int cmd_w                     = mmu_cmd_width(vaddr_width_p),
   localparam int resp_w                    = mmu_resp_width())
  (input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [els_p*cmd_w-1:0] req_cmd_i,
   input  logic [els_p-1:0]       req_v_i,
   output logic [els_p-1:0]       req_ready_o,
   output logic [cmd_w-1:0]       mmu_cmd_o,
   output logic                   mmu_cmd_v_o,
   input  logic                   mmu_cmd_ready_i,
   input  logic [resp_w-1:0]      mmu_resp_i,
   input  logic                   mmu_resp_v_i,
   output logic                   mmu_resp_ready_o,
   output logic [resp_w-1:0]      resp_o,
   output logic [els_p-1:0]       resp_v_o,
   input  logic                   flush_i,
   output logic                   busy_o,
   output logic                   err_o);

   localparam int idx_w = $clog2(els_p);
   localparam int cnt_w = $clog2(outstanding_p) + 1;

   if (els_p < 2 || els_p > 2**arb_id_width_gp || outstanding_p < 2
       || (outstanding_p & (outstanding_p - 1)) != 0
       || lce_sets_p < 1 || cce_block_size_in_bytes_p < 1) begin : g_bad_cfg
      $error("bp_be_mmu_cmd_arbiter: unsupported parameter set");
   end

   logic [cmd_w-1:0]     req_cmd [els_p];
   logic                 hold_v;
   logic [cmd_w-1:0]     hold_cmd;
   logic [idx_w-1:0]     hold_id, ptr, gnt_idx;
   logic                 gnt_found, issue, pop, accept, credit_ok, tr_empty;
   logic [cnt_w-1:0]     tr_count;
   bp_be_mmu_arb_entry_s tr_head, tr_push;

   for (genvar i = 0; i < els_p; i++) begin : g_slot
      assign req_cmd[i] = req_cmd_i[i*cmd_w +: cmd_w];
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr;
      for (int k = 1; k <= els_p; k++)
         if (!gnt_found && req_v_i[idx_w'((int'(ptr) + k) % els_p)]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx_w'((int'(ptr) + k) % els_p);
         end
   end

   assign issue     = hold_v & mmu_cmd_ready_i & ~flush_i;
   assign pop       = mmu_resp_v_i & ~tr_empty;
   // Held command counts against the credit until it retires from the tracker.
   assign credit_ok = ({1'b0, tr_count} + (cnt_w+1)'(hold_v) - (cnt_w+1)'(pop))
                      < (cnt_w+1)'(outstanding_p);
   assign accept    = ~flush_i & (~hold_v | issue) & credit_ok & gnt_found;

   assign req_ready_o      = accept ? els_p'(1) << gnt_idx : '0;
   assign mmu_cmd_o        = hold_cmd;
   assign mmu_cmd_v_o      = issue;
   assign mmu_resp_ready_o = 1'b1;
   assign resp_o           = mmu_resp_i;
   assign resp_v_o         = (pop & ~tr_head.poison) ? els_p'(1) << tr_head.id : '0;
   assign busy_o           = hold_v | ~tr_empty;
   assign tr_push          = {arb_id_width_gp'(hold_id), 1'b0};

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         hold_v   <= 1'b0;
         hold_cmd <= '0;
         hold_id  <= '0;
         ptr      <= idx_w'(rr_reset_ptr(els_p));
         err_o    <= 1'b0;
      end else begin
         if (accept) begin
            hold_v   <= 1'b1;
            hold_cmd <= req_cmd[gnt_idx];
            hold_id  <= gnt_idx;
            ptr      <= gnt_idx;
         end else if (issue | flush_i)
            hold_v <= 1'b0;
         if (mmu_resp_v_i & tr_empty)
            err_o <= 1'b1;
      end

   bp_be_mmu_id_tracker #(.depth_p(outstanding_p)) tracker
     (.clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .push_i       (issue),
      .data_i       (tr_push),
      .pop_i        (pop),
      .poison_all_i (flush_i),
      .head_o       (tr_head),
      .count_o      (tr_count),
      .empty_o      (tr_empty));

endmodule

// File: tb/tb_bp_be_mmu_cmd_arbiter.sv
// tb_bp_be_mmu_cmd_arbiter: directed and random stimulus against a queue-based reference model.
module tb_bp_be_mmu_cmd_arbiter;

   localparam int CMD_W  = 43;
   localparam int RESP_W = 66;

   logic                 clk = 1'b0;
   logic                 reset_n_i;
   logic [2*CMD_W-1:0]   req_cmd_i;
   logic [1:0]           req_v_i;
   logic [1:0]           req_ready_o;
   logic [CMD_W-1:0]     mmu_cmd_o;
   logic                 mmu_cmd_v_o;
   logic                 mmu_cmd_ready_i;
   logic [RESP_W-1:0]    mmu_resp_i;
   logic                 mmu_resp_v_i;
   logic                 mmu_resp_ready_o;
   logic [RESP_W-1:0]    resp_o;
   logic [1:0]           resp_v_o;
   logic                 flush_i;
   logic                 busy_o;
   logic                 err_o;

   bp_be_mmu_cmd_arbiter #(
      .vaddr_width_p(39), .lce_sets_p(64), .cce_block_size_in_bytes_p(64),
      .els_p(2), .outstanding_p(4)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .req_cmd_i(req_cmd_i), .req_v_i(req_v_i),
      .req_ready_o(req_ready_o), .mmu_cmd_o(mmu_cmd_o), .mmu_cmd_v_o(mmu_cmd_v_o),
      .mmu_cmd_ready_i(mmu_cmd_ready_i), .mmu_resp_i(mmu_resp_i), .mmu_resp_v_i(mmu_resp_v_i),
      .mmu_resp_ready_o(mmu_resp_ready_o), .resp_o(resp_o), .resp_v_o(resp_v_o),
      .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: pending requests, holding slot, and in-flight queue in issue order.
   bit [1:0]         pend;
   logic [CMD_W-1:0] pcmd [2];
   bit               m_hold_v;
   logic [CMD_W-1:0] m_hold_cmd;
   int               m_hold_id;
   int               m_ptr;
   bit               m_err;
   int               q_id[$];
   bit               q_poison[$];

   logic [1:0]       o_rdy, o_rv;
   logic             o_cmd_v;
   logic [CMD_W-1:0] o_cmd;
   logic [1:0]       g_seq [4];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend = 2'b00;
      m_hold_v = 1'b0;
      m_hold_cmd = '0;
      m_hold_id = 0;
      m_ptr = 1;
      m_err = 1'b0;
      q_id.delete();
      q_poison.delete();
   endtask

   // Called at a falling edge: drive, check before the rising edge, then advance the model.
   task automatic cycle(input bit [1:0] want, input bit rdy, input bit rv, input bit fl);
      bit e_issue, e_pop, en, found, accept;
      int cnt, g;
      logic [1:0] e_rdy, e_rv;
      for (int i = 0; i < 2; i++)
         if (!pend[i] && want[i]) begin
            pend[i] = 1'b1;
            pcmd[i] = CMD_W'({$urandom, $urandom});
         end
      req_v_i = pend;
      req_cmd_i = {pcmd[1], pcmd[0]};
      mmu_cmd_ready_i = rdy;
      mmu_resp_v_i = rv;
      mmu_resp_i = RESP_W'({$urandom, $urandom, $urandom});
      flush_i = fl;
      #2;
      e_issue = m_hold_v && rdy && !fl;
      e_pop = rv && q_id.size() > 0;
      cnt = int'(m_hold_v) + q_id.size();
      en = !fl && (!m_hold_v || e_issue) && (cnt - int'(e_pop) < 4);
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= 2; k++)
         if (!found && pend[(m_ptr + k) % 2]) begin
            found = 1'b1;
            g = (m_ptr + k) % 2;
         end
      accept = en && found;
      e_rdy = accept ? 2'(1 << g) : 2'b00;
      e_rv = (e_pop && !q_poison[0]) ? 2'(1 << q_id[0]) : 2'b00;
      o_rdy = req_ready_o;
      o_rv = resp_v_o;
      o_cmd_v = mmu_cmd_v_o;
      o_cmd = mmu_cmd_o;
      chk("req_ready", req_ready_o, e_rdy);
      chk("mmu_cmd_v", mmu_cmd_v_o, e_issue);
      if (e_issue) chk("mmu_cmd", mmu_cmd_o, m_hold_cmd);
      chk("resp_v", resp_v_o, e_rv);
      chk("resp_data", resp_o, mmu_resp_i);
      chk("busy", busy_o, m_hold_v || q_id.size() > 0);
      chk("err", err_o, m_err);
      chk("resp_ready", mmu_resp_ready_o, 1'b1);
      @(posedge clk);
      if (rv && q_id.size() == 0) m_err = 1'b1;
      if (e_pop) begin
         void'(q_id.pop_front());
         void'(q_poison.pop_front());
      end
      if (fl) foreach (q_poison[k]) q_poison[k] = 1'b1;
      if (e_issue) begin
         q_id.push_back(m_hold_id);
         q_poison.push_back(1'b0);
      end
      if (accept) begin
         m_hold_v = 1'b1;
         m_hold_cmd = pcmd[g];
         m_hold_id = g;
         m_ptr = g;
         pend[g] = 1'b0;
      end else if (e_issue || fl)
         m_hold_v = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && (m_hold_v || q_id.size() > 0 || pend != 0); n++)
         cycle(2'b00, 1'b1, q_id.size() > 0, 1'b0);
      chk("drained_busy", busy_o, 1'b0);
   endtask

   initial begin
      reset_n_i = 1'b0;
      req_cmd_i = '0;
      req_v_i = '0;
      mmu_cmd_ready_i = 1'b0;
      mmu_resp_i = '0;
      mmu_resp_v_i = 1'b0;
      flush_i = 1'b0;
      model_reset();
      #1;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_req_ready", req_ready_o, 2'b00);
      chk("rst_cmd_v", mmu_cmd_v_o, 1'b0);
      chk("rst_resp_v", resp_v_o, 2'b00);
      chk("rst_resp_ready", mmu_resp_ready_o, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset_n_i = 1'b1;

      for (int n = 0; n < 4; n++) begin
         cycle(2'b11, 1'b1, q_id.size() > 0, 1'b0);
         g_seq[n] = o_rdy;
      end
      chk("rr_g0", g_seq[0], 2'b01);
      chk("rr_g1", g_seq[1], 2'b10);
      chk("rr_g2", g_seq[2], 2'b01);
      chk("rr_g3", g_seq[3], 2'b10);
      drain();

      pend[1] = 1'b1;
      pcmd[1] = {4'h3, 39'h100};
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      pend[1] = 1'b1;
      pcmd[1] = {4'h3, 39'h108};
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      chk("vaddr_100", o_cmd[38:0], 39'h100);
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("vaddr_108", o_cmd[38:0], 39'h108);
      chk("resp_req1_a", o_rv, 2'b10);
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("resp_req1_b", o_rv, 2'b10);
      drain();

      for (int n = 0; n < 8; n++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
      chk("credit_stall", o_rdy, 2'b00);
      cycle(2'b11, 1'b1, 1'b1, 1'b0);
      chk("grant_on_pop", o_rdy != 2'b00, 1'b1);
      drain();

      cycle(2'b01, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) cycle(2'b10, 1'b0, 1'b0, 1'b0);
      chk("stall_ready", o_rdy, 2'b00);
      chk("stall_cmd_v", o_cmd_v, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      chk("stall_issue", o_cmd_v, 1'b1);
      chk("stall_regrant", o_rdy, 2'b10);
      drain();

      cycle(2'b11, 1'b1, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      chk("flush_inflight", q_id.size(), 2);
      cycle(2'b00, 1'b1, 1'b0, 1'b1);
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("flush_resp0", o_rv, 2'b00);
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("flush_resp1", o_rv, 2'b00);
      cycle(2'b01, 1'b1, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("post_flush_resp", o_rv, 2'b01);
      drain();

      for (int n = 0; n < 400; n++)
         cycle(2'($urandom), $urandom_range(0, 3) != 0,
               q_id.size() > 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      drain();

      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      chk("err_set", err_o, 1'b1);
      for (int n = 0; n < 3; n++) cycle(2'b00, 1'b1, 1'b0, 1'b0);
      chk("err_sticky", err_o, 1'b1);

      for (int n = 0; n < 3; n++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
      #1;
      reset_n_i = 1'b0;
      req_v_i = '0;
      mmu_resp_v_i = 1'b0;
      #1;
      chk("async_rst_busy", busy_o, 1'b0);
      chk("async_rst_err", err_o, 1'b0);
      model_reset();
      @(negedge clk);
      reset_n_i = 1'b1;
      cycle(2'b00, 1'b1, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0);
      chk("err_after_reset", err_o, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
